// File: rtl/counter_display_driver.sv
// counter_display_driver
//   Converts an 8-bit count into three display digits and drives a
//   multiplexed 3-digit, 7-segment display.
//   - Decimal mode: the digits come from a serial shift-add-3
//     (double-dabble) conversion that takes 8 cycles.
//   - Hex mode: the digits are taken straight from the value nibbles.
//   All three digits are updated together when a conversion commits.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   value_in   in   [7:0] count value from the upstream counter
//   mode       in   0 = unsigned decimal, 1 = hexadecimal
//   blank_lz   in   1 = blank leading zero digits
//   seg        out  [6:0] {g,f,e,d,c,b,a}, active-high, registered
//   digit_sel  out  [2:0] one-hot digit enable, bit 0 = LSD, registered
//   busy       out  high during CONVERT and COMMIT
//   updated    out  one-cycle pulse in the COMMIT cycle
module counter_display_driver #(
    parameter int SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value_in,
    input  logic       mode,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] digit_sel,
    output logic       busy,
    output logic       updated
);

    localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       last_value_q, last_value_d;
    logic             last_mode_q, last_mode_d;
    // Working register {bcd[11:0], binary[7:0]}; the pending digits sit in
    // the upper 12 bits by the time COMMIT is reached (in either mode).
    logic [19:0]      work_q, work_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [3:0]       d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       sel_q, sel_d;

    logic [19:0]      adj;
    logic [3:0]       cur_digit;
    logic             cur_blank;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Conversion FSM
    always_comb begin
        state_d      = state_q;
        last_value_d = last_value_q;
        last_mode_d  = last_mode_q;
        work_d       = work_q;
        bitcnt_d     = bitcnt_q;
        d2_d         = d2_q;
        d1_d         = d1_q;
        d0_d         = d0_q;
        adj          = work_q;

        case (state_q)
            IDLE: begin
                if ((value_in != last_value_q) || (mode != last_mode_q)) begin
                    last_value_d = value_in;
                    last_mode_d  = mode;
                    bitcnt_d     = '0;
                    if (mode) begin
                        // Hex digits need no conversion: preload them.
                        work_d  = {4'h0, value_in, 8'h00};
                        state_d = COMMIT;
                    end else begin
                        work_d  = {12'h000, value_in};
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (adj[8 + 4*i +: 4] >= 4'd5) begin
                        adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
                    end
                end
                work_d   = {adj[18:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                d2_d    = work_q[19:16];
                d1_d    = work_q[15:12];
                d0_d    = work_q[11:8];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Display scanning
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        cur_digit = d0_q;
        cur_blank = 1'b0;
        sel_d     = 3'b001;
        case (idx_q)
            2'd1: begin
                cur_digit = d1_q;
                cur_blank = blank_lz && (d2_q == 4'h0) && (d1_q == 4'h0);
                sel_d     = 3'b010;
            end
            2'd2: begin
                cur_digit = d2_q;
                cur_blank = blank_lz && (d2_q == 4'h0);
                sel_d     = 3'b100;
            end
            default: begin
                cur_digit = d0_q;
                cur_blank = 1'b0;
                sel_d     = 3'b001;
            end
        endcase
        seg_d = cur_blank ? '0 : encode(cur_digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_value_q <= '0;
            last_mode_q  <= 1'b0;
            work_q       <= '0;
            bitcnt_q     <= '0;
            d2_q         <= '0;
            d1_q         <= '0;
            d0_q         <= '0;
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            seg_q        <= '0;
            sel_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_value_q <= last_value_d;
            last_mode_q  <= last_mode_d;
            work_q       <= work_d;
            bitcnt_q     <= bitcnt_d;
            d2_q         <= d2_d;
            d1_q         <= d1_d;
            d0_q         <= d0_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = sel_q;
    assign busy      = (state_q != IDLE);
    assign updated   = (state_q == COMMIT);

endmodule

// File: tb/tb_counter_display_driver.sv
// tb_counter_display_driver
//   Directed bench for counter_display_driver with SCAN_DIV = 4.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_counter_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value_in;
    logic       mode;
    logic       blank_lz;
    logic [6:0] seg;
    logic [2:0] digit_sel;
    logic       busy;
    logic       updated;

    int errors = 0;
    int checks = 0;

    counter_display_driver #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .mode      (mode),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .digit_sel (digit_sel),
        .busy      (busy),
        .updated   (updated)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Collects the segment pattern shown on each digit over one full scan.
    task automatic read_display(output logic [6:0] s0, output logic [6:0] s1,
                                output logic [6:0] s2);
        s0 = 'x; s1 = 'x; s2 = 'x;
        tick;
        repeat (13) begin
            tick;
            case (digit_sel)
                3'b001: s0 = seg;
                3'b010: s1 = seg;
                3'b100: s2 = seg;
                default: ;
            endcase
        end
    endtask

    // Bounded wait for a conversion started by the current inputs to finish.
    task automatic settle(input string name);
        int n = 0;
        tick;
        while (busy && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b, required 0 within 40 cycles", name, busy);
        end
    endtask

    task automatic test_reset;
        logic [2:0] es;
        logic [6:0] eg;
        rst = 1'b1; value_in = 8'd0; mode = 1'b0; blank_lz = 1'b1;
        repeat (3) tick;
        checks++; if (seg !== 7'h00) begin errors++; $display("FAIL rst_seg: got %h, expected 00", seg); end
        checks++; if (digit_sel !== 3'b000) begin errors++; $display("FAIL rst_sel: got %b, expected 000", digit_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        checks++; if (updated !== 1'b0) begin errors++; $display("FAIL rst_updated: got %b, expected 0", updated); end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick;
            es = (k <= 4) ? 3'b001 : (k <= 8) ? 3'b010 : 3'b100;
            eg = (k <= 4) ? 7'h3F : 7'h00;
            checks++; if (digit_sel !== es) begin errors++; $display("FAIL scan_sel[%0d]: got %b, expected %b", k, digit_sel, es); end
            checks++; if (seg !== eg) begin errors++; $display("FAIL scan_seg[%0d]: got %h, expected %h", k, seg, eg); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_busy[%0d]: got %b, expected 0", k, busy); end
        end
    endtask

    task automatic test_decimal;
        logic [6:0] s0, s1, s2;
        value_in = 8'd255;
        tick;
        for (int i = 0; i <= 8; i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dec_busy[%0d]: got %b, expected 1", i, busy); end
            checks++; if (updated !== (i == 8)) begin errors++; $display("FAIL dec_updated[%0d]: got %b, expected %b", i, updated, (i == 8)); end
            tick;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dec_busy_end: got %b, expected 0", busy); end
        checks++; if (updated !== 1'b0) begin errors++; $display("FAIL dec_updated_end: got %b, expected 0", updated); end
        read_display(s0, s1, s2);
        checks++; if (s0 !== 7'h6D) begin errors++; $display("FAIL dec255_d0: got %h, expected 6D", s0); end
        checks++; if (s1 !== 7'h6D) begin errors++; $display("FAIL dec255_d1: got %h, expected 6D", s1); end
        checks++; if (s2 !== 7'h5B) begin errors++; $display("FAIL dec255_d2: got %h, expected 5B", s2); end
    endtask

    task automatic test_hex;
        logic [6:0] s0, s1, s2;
        value_in = 8'hA7; mode = 1'b1;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hex_busy: got %b, expected 1", busy); end
        checks++; if (updated !== 1'b1) begin errors++; $display("FAIL hex_updated: got %b, expected 1", updated); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hex_busy_end: got %b, expected 0", busy); end
        read_display(s0, s1, s2);
        checks++; if (s0 !== 7'h07) begin errors++; $display("FAIL hexA7_d0: got %h, expected 07", s0); end
        checks++; if (s1 !== 7'h77) begin errors++; $display("FAIL hexA7_d1: got %h, expected 77", s1); end
        checks++; if (s2 !== 7'h00) begin errors++; $display("FAIL hexA7_d2: got %h, expected 00", s2); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] s0, s1, s2;
        int n_upd = 0;
        int first_at = -1;
        int second_at = -1;
        mode = 1'b0; value_in = 8'd100;
        tick;               // capture edge
        tick; tick;         // third CONVERT cycle
        value_in = 8'd37;
        for (int i = 2; i <= 30; i++) begin
            if (updated === 1'b1) begin
                n_upd++;
                if (first_at < 0) first_at = i; else if (second_at < 0) second_at = i;
            end
            if (i == 9) begin
                checks++;
                if ({dut.d2_q, dut.d1_q, dut.d0_q} !== 12'h100) begin
                    errors++;
                    $display("FAIL b2b_first_commit: got %h, expected 100", {dut.d2_q, dut.d1_q, dut.d0_q});
                end
            end
            tick;
        end
        checks++; if (n_upd !== 2) begin errors++; $display("FAIL b2b_commit_count: got %0d, expected 2", n_upd); end
        checks++; if (first_at !== 8) begin errors++; $display("FAIL b2b_first_at: got %0d, expected 8", first_at); end
        checks++; if (second_at !== 18) begin errors++; $display("FAIL b2b_second_at: got %0d, expected 18", second_at); end
        read_display(s0, s1, s2);
        checks++; if (s0 !== 7'h07) begin errors++; $display("FAIL b2b_d0: got %h, expected 07", s0); end
        checks++; if (s1 !== 7'h4F) begin errors++; $display("FAIL b2b_d1: got %h, expected 4F", s1); end
        checks++; if (s2 !== 7'h00) begin errors++; $display("FAIL b2b_d2: got %h, expected 00", s2); end
    endtask

    task automatic test_reset_abort;
        logic [6:0] s0, s1, s2;
        value_in = 8'd200;
        tick;               // capture edge, first CONVERT cycle
        repeat (4) tick;    // fifth CONVERT cycle
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        checks++; if (updated !== 1'b0) begin errors++; $display("FAIL abort_updated: got %b, expected 0", updated); end
        tick;
        checks++;
        if ({dut.d2_q, dut.d1_q, dut.d0_q} !== 12'h000) begin
            errors++;
            $display("FAIL abort_digits: got %h, expected 000", {dut.d2_q, dut.d1_q, dut.d0_q});
        end
        rst = 1'b0;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_recapture: got %b, expected 1", busy); end
        repeat (8) tick;
        checks++; if (updated !== 1'b1) begin errors++; $display("FAIL abort_recommit: got %b, expected 1", updated); end
        tick;
        read_display(s0, s1, s2);
        checks++; if (s0 !== 7'h3F) begin errors++; $display("FAIL abort200_d0: got %h, expected 3F", s0); end
        checks++; if (s1 !== 7'h3F) begin errors++; $display("FAIL abort200_d1: got %h, expected 3F", s1); end
        checks++; if (s2 !== 7'h5B) begin errors++; $display("FAIL abort200_d2: got %h, expected 5B", s2); end
    endtask

    task automatic test_mode_toggle;
        logic [6:0] s0, s1, s2;
        value_in = 8'd15; mode = 1'b0;
        settle("dec15");
        read_display(s0, s1, s2);
        checks++; if ({s2, s1, s0} !== {7'h00, 7'h06, 7'h6D}) begin errors++; $display("FAIL dec15: got %h/%h/%h, expected 00/06/6D", s2, s1, s0); end
        mode = 1'b1;
        tick;
        checks++; if (updated !== 1'b1) begin errors++; $display("FAIL toggle_hex_updated: got %b, expected 1", updated); end
        tick;
        read_display(s0, s1, s2);
        checks++; if ({s2, s1, s0} !== {7'h00, 7'h00, 7'h71}) begin errors++; $display("FAIL hex0F: got %h/%h/%h, expected 00/00/71", s2, s1, s0); end
        mode = 1'b0;
        settle("back_dec15");
        read_display(s0, s1, s2);
        checks++; if ({s2, s1, s0} !== {7'h00, 7'h06, 7'h6D}) begin errors++; $display("FAIL back_dec15: got %h/%h/%h, expected 00/06/6D", s2, s1, s0); end
        blank_lz = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL blank_no_busy: got %b, expected 0", busy); end
        read_display(s0, s1, s2);
        checks++; if ({s2, s1, s0} !== {7'h3F, 7'h06, 7'h6D}) begin errors++; $display("FAIL noblank15: got %h/%h/%h, expected 3F/06/6D", s2, s1, s0); end
    endtask

    initial begin
        test_reset;
        test_decimal;
        test_hex;
        test_back_to_back;
        test_reset_abort;
        test_mode_toggle;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
